// File: rtl/arbiter3_grant_ctl.sv
// rtl/arbiter3_grant_ctl.sv - registered grant controller with candidate validation and round-robin fallback
module arbiter3_grant_ctl #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [2:0]       cand,
    input  logic             cand_vld,
    output logic [2:0]       gnt,
    output logic [2:0]       tok,
    output logic             viol,
    output logic             tmo,
    output logic [CNT_W-1:0] viol_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [2:0]       tok_q, tok_d;
    logic [7:0]       hcnt_q, hcnt_d;
    logic             viol_q, viol_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;

    logic             cand_onehot;
    logic             cand_ok;
    logic [2:0]       fb_gnt;
    logic [2:0]       tok_next;
    logic             released;
    logic             timed_out;

    // Candidate check, fallback scan starting at the token, and grant-end helpers
    always_comb begin
        cand_onehot = (cand == 3'b001) || (cand == 3'b010) || (cand == 3'b100);
        cand_ok     = cand_vld && cand_onehot && ((cand & ~req) == 3'b000);

        fb_gnt = 3'b000;
        case (tok_q)
            3'b010: begin
                if (req[1])      fb_gnt = 3'b010;
                else if (req[2]) fb_gnt = 3'b100;
                else if (req[0]) fb_gnt = 3'b001;
            end
            3'b100: begin
                if (req[2])      fb_gnt = 3'b100;
                else if (req[0]) fb_gnt = 3'b001;
                else if (req[1]) fb_gnt = 3'b010;
            end
            default: begin
                if (req[0])      fb_gnt = 3'b001;
                else if (req[1]) fb_gnt = 3'b010;
                else if (req[2]) fb_gnt = 3'b100;
            end
        endcase

        // Token moves to the client after the one whose grant is ending
        tok_next  = {gnt_q[1:0], gnt_q[2]};
        released  = ((req & gnt_q) == 3'b000);
        timed_out = (hcnt_q == 8'(HOLD_MAX));
    end

    // Next-state and output decisions; release takes precedence over timeout
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        tok_d      = tok_q;
        hcnt_d     = hcnt_q;
        viol_d     = 1'b0;
        tmo_d      = 1'b0;
        viol_cnt_d = viol_cnt_q;

        case (state_q)
            IDLE: begin
                gnt_d = 3'b000;
                if (req != 3'b000) begin
                    state_d = GRANT;
                    hcnt_d  = 8'd1;
                    if (cand_ok) begin
                        gnt_d = cand;
                    end else begin
                        gnt_d = fb_gnt;
                        if (cand_vld) begin
                            viol_d = 1'b1;
                            if (!(&viol_cnt_q))
                                viol_cnt_d = viol_cnt_q + 1'b1;
                        end
                    end
                end
            end
            GRANT: begin
                if (released) begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                    tok_d   = tok_next;
                end else if (timed_out) begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                    tok_d   = tok_next;
                    tmo_d   = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 3'b000;
            tok_q      <= 3'b001;
            hcnt_q     <= 8'd0;
            viol_q     <= 1'b0;
            tmo_q      <= 1'b0;
            viol_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            tok_q      <= tok_d;
            hcnt_q     <= hcnt_d;
            viol_q     <= viol_d;
            tmo_q      <= tmo_d;
            viol_cnt_q <= viol_cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign tok      = tok_q;
    assign viol     = viol_q;
    assign tmo      = tmo_q;
    assign viol_cnt = viol_cnt_q;

endmodule

// File: tb/tb_arbiter3_grant_ctl.sv
// tb/tb_arbiter3_grant_ctl.sv - scoreboard bench for arbiter3_grant_ctl with directed vectors
module tb_arbiter3_grant_ctl;

    localparam int HOLD_MAX = 4;
    localparam int CNT_W    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req;
    logic [2:0]       cand;
    logic             cand_vld;
    logic [2:0]       gnt;
    logic [2:0]       tok;
    logic             viol;
    logic             tmo;
    logic [CNT_W-1:0] viol_cnt;

    typedef struct packed {
        logic [2:0]       gnt;
        logic [2:0]       tok;
        logic             viol;
        logic             tmo;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   step_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    arbiter3_grant_ctl #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .cand     (cand),
        .cand_vld (cand_vld),
        .gnt      (gnt),
        .tok      (tok),
        .viol     (viol),
        .tmo      (tmo),
        .viol_cnt (viol_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [2:0] rq, input logic [2:0] cd, input logic vl,
                        input logic [2:0] eg, input logic [2:0] et, input logic ev, input logic em,
                        input int ec);
        exp_t e;
        @(negedge clk);
        rst      = r;
        req      = rq;
        cand     = cd;
        cand_vld = vl;
        e.gnt  = eg;
        e.tok  = et;
        e.viol = ev;
        e.tmo  = em;
        e.cnt  = CNT_W'(ec);
        step_no++;
        exp_q.push_back(e);
        step_q.push_back(step_no);
    endtask

    task automatic check3(input string nm, input int s, input logic [2:0] act, input logic [2:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL step %0d %s: got %b expected %b", s, nm, act, req_v);
        end
    endtask

    // Monitor: every cycle after the edge, compare the DUT against the oldest expectation
    initial begin
        exp_t e;
        int   s;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                s = step_q.pop_front();
                check3("gnt", s, gnt, e.gnt);
                check3("tok", s, tok, e.tok);
                check3("viol", s, {2'b00, viol}, {2'b00, e.viol});
                check3("tmo", s, {2'b00, tmo}, {2'b00, e.tmo});
                check3("viol_cnt", s, {1'b0, viol_cnt}, {1'b0, e.cnt});
            end
        end
    end

    initial begin
        int waited;
        rst = 1'b1; req = 3'b000; cand = 3'b000; cand_vld = 1'b0;

        //     rst  req     cand    vld   gnt     tok     viol  tmo   cnt
        step(1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 0);
        // valid candidate, hold, release
        step(1'b0, 3'b101, 3'b001, 1'b1, 3'b001, 3'b001, 1'b0, 1'b0, 0);
        step(1'b0, 3'b101, 3'b000, 1'b0, 3'b001, 3'b001, 1'b0, 1'b0, 0);
        step(1'b0, 3'b100, 3'b000, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 0);
        // non-one-hot candidate, fallback from tok=010 picks client 2
        step(1'b0, 3'b101, 3'b011, 1'b1, 3'b100, 3'b010, 1'b1, 1'b0, 1);
        step(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 1);
        // candidate for non-requesting client
        step(1'b0, 3'b010, 3'b100, 1'b1, 3'b010, 3'b001, 1'b1, 1'b0, 2);
        step(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 2);
        step(1'b0, 3'b010, 3'b100, 1'b0, 3'b010, 3'b100, 1'b0, 1'b0, 2);
        step(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 2);
        // cand_vld with no requests is ignored
        step(1'b0, 3'b000, 3'b111, 1'b1, 3'b000, 3'b100, 1'b0, 1'b0, 2);
        // hold timeout after HOLD_MAX=4 cycles, then re-grant
        step(1'b0, 3'b001, 3'b000, 1'b0, 3'b001, 3'b100, 1'b0, 1'b0, 2);
        step(1'b0, 3'b001, 3'b000, 1'b0, 3'b001, 3'b100, 1'b0, 1'b0, 2);
        step(1'b0, 3'b001, 3'b000, 1'b0, 3'b001, 3'b100, 1'b0, 1'b0, 2);
        step(1'b0, 3'b001, 3'b000, 1'b0, 3'b001, 3'b100, 1'b0, 1'b0, 2);
        step(1'b0, 3'b001, 3'b000, 1'b0, 3'b000, 3'b010, 1'b0, 1'b1, 2);
        step(1'b0, 3'b001, 3'b000, 1'b0, 3'b001, 3'b010, 1'b0, 1'b0, 2);
        // release coincides with timeout: release wins
        step(1'b0, 3'b001, 3'b000, 1'b0, 3'b001, 3'b010, 1'b0, 1'b0, 2);
        step(1'b0, 3'b001, 3'b000, 1'b0, 3'b001, 3'b010, 1'b0, 1'b0, 2);
        step(1'b0, 3'b001, 3'b000, 1'b0, 3'b001, 3'b010, 1'b0, 1'b0, 2);
        step(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 2);
        // reset in the middle of a grant
        step(1'b0, 3'b010, 3'b010, 1'b1, 3'b010, 3'b010, 1'b0, 1'b0, 2);
        step(1'b1, 3'b010, 3'b010, 1'b1, 3'b000, 3'b001, 1'b0, 1'b0, 0);
        // counter saturation at 3 with CNT_W=2
        step(1'b0, 3'b001, 3'b000, 1'b1, 3'b001, 3'b001, 1'b1, 1'b0, 1);
        step(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 1);
        step(1'b0, 3'b001, 3'b000, 1'b1, 3'b001, 3'b010, 1'b1, 1'b0, 2);
        step(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 2);
        step(1'b0, 3'b001, 3'b000, 1'b1, 3'b001, 3'b010, 1'b1, 1'b0, 3);
        step(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 3);
        step(1'b0, 3'b001, 3'b000, 1'b1, 3'b001, 3'b010, 1'b1, 1'b0, 3);
        step(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 3);
        step(1'b0, 3'b001, 3'b000, 1'b1, 3'b001, 3'b010, 1'b1, 1'b0, 3);
        step(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 3);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arbiter3_grant_ctl.md
# arbiter3_grant_ctl

Sequential grant controller for the 3-requester arbiter benchmark. It consumes the three candidate grant bits produced by the combinational Skolem basis functions, one per grant output. It validates each candidate against the live requests, registers the grant, and maintains the round-robin priority token that feeds back into the basis-function inputs. Invalid candidates are replaced by a built-in round-robin fallback and counted, so the arbiter stays correct while basis functions are swapped in and out.

## Interface

Parameters:
- HOLD_MAX, default 16: maximum consecutive cycles a grant may be held before forced revocation; legal range 1..255.
- CNT_W, default 8: width of the violation counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  3  request per client; bit i belongs to client i
- cand  in  3  candidate grant vector from basis stages B0/B1/B2 (bit i from Bi)
- cand_vld  in  1  cand is meaningful this cycle
- gnt  out  3  registered grant, one-hot or zero
- tok  out  3  one-hot priority token; feeds basis-function inputs
- viol  out  1  one-cycle pulse: candidate rejected this arbitration
- tmo  out  1  one-cycle pulse: grant revoked by hold timeout
- viol_cnt  out  CNT_W  saturating count of rejected candidates

## Operation

- State machine with two states, IDLE and GRANT, plus an 8-bit hold counter hcnt.
- Reset values: state=IDLE, gnt=000, tok=001, hcnt=0, viol=0, tmo=0, viol_cnt=0.

IDLE:
- If req==000, stay in IDLE with gnt=000. cand and cand_vld are ignored and no violation is raised.
- If req!=000, a candidate is valid when all of the following hold: cand_vld=1, cand is exactly one-hot, and (cand & ~req)==000.
- Valid candidate: gnt<=cand.
- Otherwise, fallback: gnt<=the first requesting client found by scanning from the tok position upward modulo 3. Example: tok=010 scans 1, 2, 0.
- Fallback with cand_vld=1: viol pulses and viol_cnt increments. viol_cnt saturates at 2^CNT_W-1.
- Fallback with cand_vld=0: no violation is raised.
- In both cases: go to GRANT and set hcnt<=1.

GRANT:
- The granted client is g. Each cycle, check in this priority order:
  1. req[g]==0 (release): gnt<=000, tok<=one-hot of (g+1) mod 3, go to IDLE.
  2. hcnt==HOLD_MAX (timeout): gnt<=000, tok<=one-hot of (g+1) mod 3, tmo pulses, go to IDLE.
  3. Otherwise: hold gnt and increment hcnt.
- In GRANT, cand, cand_vld and the other req bits are ignored.

Invariants:
- gnt is always one-hot or zero.
- A newly issued gnt bit is always a subset of the req value sampled on that cycle.
- tok is always one-hot and changes only when a grant ends.

## Timing

- Grant latency: req sampled in cycle t (IDLE) gives gnt valid in cycle t+1.
- Release latency: req[g] low in cycle t gives gnt=000 in cycle t+1.
- At least one cycle with gnt=000 separates any two grants, including a re-grant to the same client.
- A grant raised at cycle t+1 is held for at most HOLD_MAX cycles, t+1 through t+HOLD_MAX. gnt=000 at t+HOLD_MAX+1, with tmo=1 in that same cycle.
- Release and timeout in the same cycle: release wins and tmo stays 0. tok advances identically in both cases.
- viol and tmo are high for exactly the one cycle after the deciding edge.
- rst asserted mid-grant: on the next edge all state returns to reset values, regardless of req.
- tok is registered. Its new value is visible to the basis functions in the same cycle that gnt drops to 000.

## Test plan

- Reset, then req=101, cand=001, cand_vld=1 -> next cycle gnt=001, viol=0. Hold req -> gnt stays 001. Drop req[0] -> gnt=000, tok=010.
- tok=010, req=101, cand=011, cand_vld=1 (not one-hot) -> gnt=100 by fallback scan (client 2 first), viol=1, viol_cnt=1.
- req=010, cand=100, cand_vld=1 (ungranted client) -> gnt=010, viol=1. Repeat with cand_vld=0 -> gnt=010, viol=0, count unchanged.
- HOLD_MAX=4, req=001 held continuously -> gnt=001 for exactly 4 cycles, then gnt=000 with tmo=1 and tok=010, then gnt=001 re-granted one cycle later.
- Release and timeout coincide on cycle HOLD_MAX -> gnt=000, tmo=0. Separately, assert rst during GRANT -> gnt=000, tok=001, viol_cnt=0 on the next edge.
- CNT_W=2 with 5 consecutive invalid candidates -> viol_cnt sequence 1, 2, 3, 3, 3. viol pulses every arbitration.
